// File: rtl/lynx_pkg.sv
// -----------------------------------------------------------------------------
// lynx_pkg
// Shared definitions for the boot-time ROM-to-RAM copier:
//   - ST_* constants   : raw 2-bit FSM encodings, for legacy code that
//                        compares plain vectors
//   - loader_state_t   : FSM state enum (FETCH, LATCH, WRITE, DONE) built
//                        on the ST_* encodings
//   - RST_* constants  : reset values of the loader's control registers
// -----------------------------------------------------------------------------
package lynx_pkg;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_LATCH = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        FETCH = ST_FETCH,
        LATCH = ST_LATCH,
        WRITE = ST_WRITE,
        DONE  = ST_DONE
    } loader_state_t;

    localparam loader_state_t RST_STATE = FETCH;
    localparam logic          RST_BUSY  = 1'b1;
    localparam logic          RST_DONE  = 1'b0;
    localparam logic          RST_REQ   = 1'b0;
    localparam logic          RST_ACKF  = 1'b0;
    localparam logic [7:0]    RST_SUM   = 8'h00;
    localparam logic          RST_OK    = 1'b0;

endpackage

// File: rtl/rom_loader_if.sv
// -----------------------------------------------------------------------------
// rom_loader_if
// Bundles the ROM read port and the RAM write handshake used by rom_loader.
// Parameters: RAW (ROM word address width), DW (data width), AW (RAM address
// width).
// Signals:
//   rom_ce  : ROM read enable               (loader -> ROM)
//   rom_a   : ROM word address              (loader -> ROM)
//   rom_q   : ROM data, registered in ROM   (ROM -> loader)
//   ram_req : write request, level          (loader -> RAM ctrl)
//   ram_we  : write strobe, equals ram_req  (loader -> RAM ctrl)
//   ram_a   : RAM write address             (loader -> RAM ctrl)
//   ram_d   : RAM write data                (loader -> RAM ctrl)
//   ram_ack : write accepted, 1-cycle pulse (RAM ctrl -> loader)
// Modports: master = loader side, slave = ROM / RAM-controller side.
// -----------------------------------------------------------------------------
interface rom_loader_if #(
    parameter int RAW = 14,
    parameter int DW  = 8,
    parameter int AW  = 18
) ();

    logic            rom_ce;
    logic [RAW-1:0]  rom_a;
    logic [DW-1:0]   rom_q;
    logic            ram_req;
    logic            ram_we;
    logic [AW-1:0]   ram_a;
    logic [DW-1:0]   ram_d;
    logic            ram_ack;

    modport master (
        output rom_ce, rom_a, ram_req, ram_we, ram_a, ram_d,
        input  rom_q, ram_ack
    );

    modport slave (
        input  rom_ce, rom_a, ram_req, ram_we, ram_a, ram_d,
        output rom_q, ram_ack
    );

endinterface

// File: rtl/rom_loader.sv
// -----------------------------------------------------------------------------
// rom_loader
// Copies the ROM image (N = KB*1024 words) into RAM starting at BASE before
// the CPU leaves reset. Each word goes FETCH (ROM read) -> LATCH (capture
// rom_q) -> WRITE (hold ram_req until acked), then the next word; after the
// last word the FSM parks in DONE.
//
// Optional feature macro: ROM_CHECKSUM_EN adds parameter SUM and the ports
// sum/ok (running 8-bit checksum of the copied words and the match flag).
//
// Ports:
//   clock : system clock
//   reset : synchronous active-high reset
//   ce    : clock enable for the FSM (ack sampling ignores it)
//   bus   : rom_loader_if.master (ROM read port + RAM write handshake)
//   busy  : copy in progress (holds the CPU in reset)
//   done  : copy complete, sticky until reset
//   sum   : running checksum                 (ROM_CHECKSUM_EN only)
//   ok    : done & (sum == SUM)              (ROM_CHECKSUM_EN only)
// -----------------------------------------------------------------------------
module rom_loader
    import lynx_pkg::*;
#(
    parameter int KB   = 16,
    parameter int DW   = 8,
    parameter int AW   = 18,
    parameter int BASE = 0
`ifdef ROM_CHECKSUM_EN
    ,
    parameter logic [7:0] SUM = 8'h00
`endif
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ce,
    rom_loader_if.master bus,
    output logic         busy,
    output logic         done
`ifdef ROM_CHECKSUM_EN
    ,
    output logic [7:0]   sum,
    output logic         ok
`endif
);

    localparam int N   = KB * 1024;
    localparam int RAW = $clog2(N);

    localparam logic [RAW-1:0] LAST_IDX = RAW'(N - 1);
    localparam logic [RAW-1:0] IDX_ZERO = {RAW{1'b0}};
    localparam logic [RAW-1:0] IDX_ONE  = {{(RAW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]  BASE_A   = AW'(BASE);
    localparam logic [AW-1:0]  ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]  DATA_ZERO = {DW{1'b0}};

    loader_state_t  state_q, state_d;
    logic [RAW-1:0] idx_q, idx_d;
    logic [AW-1:0]  ram_a_q, ram_a_d;
    logic [DW-1:0]  ram_d_q, ram_d_d;
    logic           req_q, req_d;
    logic           ack_flag_q, ack_flag_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           ack_s;
    logic           acked_s;

`ifdef ROM_CHECKSUM_EN
    logic [7:0]     sum_q, sum_d;
    logic           ok_q, ok_d;

    // Low byte of a data word, zero-extended first so narrow DW still works.
    function automatic logic [7:0] low8(input logic [DW-1:0] w);
        logic [DW+7:0] ext;
        ext = {8'h00, w};
        return ext[7:0];
    endfunction
`endif

    // An ack only counts while a request is outstanding; acks seen with
    // ram_req low are discarded.
    assign ack_s   = bus.ram_ack & req_q;
    // The WRITE state may leave on the very edge the ack is sampled, or later
    // from the sticky flag if that edge had ce low.
    assign acked_s = ack_flag_q | ack_s;

    // Next-state logic: FSM sequencing, index/address advance, handshake, checksum
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ram_a_d    = ram_a_q;
        ram_d_d    = ram_d_q;
        req_d      = req_q;
        ack_flag_d = ack_flag_q;
        busy_d     = busy_q;
        done_d     = done_q;
`ifdef ROM_CHECKSUM_EN
        sum_d      = sum_q;
        ok_d       = ok_q;
`endif

        // Handshake sampling runs every edge, independent of ce.
        if (ack_s) begin
            req_d      = 1'b0;
            ack_flag_d = 1'b1;
        end else begin
            req_d      = req_q;
            ack_flag_d = ack_flag_q;
        end

        case (state_q)
            FETCH: begin
                if (ce) begin
                    state_d = LATCH;
                end else begin
                    state_d = FETCH;
                end
            end
            LATCH: begin
                if (ce) begin
                    state_d = WRITE;
                    ram_d_d = bus.rom_q;
                    req_d   = 1'b1;
`ifdef ROM_CHECKSUM_EN
                    sum_d   = sum_q + low8(bus.rom_q);
`endif
                end else begin
                    state_d = LATCH;
                end
            end
            WRITE: begin
                if (ce && acked_s) begin
                    ack_flag_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`ifdef ROM_CHECKSUM_EN
                        ok_d    = (sum_q == SUM);
`endif
                    end else begin
                        state_d = FETCH;
                        idx_d   = idx_q + IDX_ONE;
                        ram_a_d = ram_a_q + ADDR_ONE;
                    end
                end else begin
                    state_d = WRITE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Register update with synchronous active-high reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RST_STATE;
            idx_q      <= IDX_ZERO;
            ram_a_q    <= BASE_A;
            ram_d_q    <= DATA_ZERO;
            req_q      <= RST_REQ;
            ack_flag_q <= RST_ACKF;
            busy_q     <= RST_BUSY;
            done_q     <= RST_DONE;
`ifdef ROM_CHECKSUM_EN
            sum_q      <= RST_SUM;
            ok_q       <= RST_OK;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ram_a_q    <= ram_a_d;
            ram_d_q    <= ram_d_d;
            req_q      <= req_d;
            ack_flag_q <= ack_flag_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef ROM_CHECKSUM_EN
            sum_q      <= sum_d;
            ok_q       <= ok_d;
`endif
        end
    end

    // rom_ce must be combinational so the ROM's registered output is ready in
    // LATCH, one ce after the read; it is gated off while reset is asserted.
    assign bus.rom_ce  = ce & (state_q == FETCH) & ~reset;
    assign bus.rom_a   = idx_q;
    assign bus.ram_req = req_q;
    assign bus.ram_we  = req_q;
    assign bus.ram_a   = ram_a_q;
    assign bus.ram_d   = ram_d_q;
    assign busy        = busy_q;
    assign done        = done_q;
`ifdef ROM_CHECKSUM_EN
    assign sum         = sum_q;
    assign ok          = ok_q;
`endif

endmodule
